mem_access_unit: RTL and testbench

- MEM stage of the flowCPU_mips five-stage pipeline. It consumes the EX/MEM pipeline register outputs and performs loads and stores on the data bus through a req/ack handshake.
- Raises a stall request while an access is outstanding.
- Registers the result into the WB stage, so it also acts as the MEM/WB latch.
- Target size: 120-400 lines of RTL.

---
 rtl/mem_access_unit_pkg.sv | 58 +++++
 rtl/mem_load_fmt.sv | 27 ++
 rtl/mem_access_unit.sv | 142 ++++++++++++++
 tb/tb_mem_access_unit.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg: shared defines for the MEM stage of the flowCPU_mips pipeline
//   - aluop codes for loads/stores, register bus typedefs, stall constants
//   - helper functions that decode an aluop into load/store, access size and lane data
package mem_access_unit_pkg;

   typedef logic [4:0]  RegAddrBus;
   typedef logic [31:0] RegBus;

   localparam RegBus     ZEROWORD   = 32'h0000_0000;
   localparam RegAddrBus NOPRegAddr = 5'b00000;

   localparam logic STALL   = 1'b1;
   localparam logic NOSTALL = 1'b0;

   localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
   localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
   localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
   localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
   localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
   localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
   localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
   localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

   typedef enum logic {IDLE, BUSY} mem_state_e;
   typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} acc_size_e;

   function automatic logic is_load(input logic [7:0] op);
      return op inside {EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP};
   endfunction

   function automatic logic is_store(input logic [7:0] op);
      return op inside {EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};
   endfunction

   function automatic acc_size_e acc_size(input logic [7:0] op);
      return (op inside {EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP}) ? SZ_B :
             (op inside {EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP}) ? SZ_H : SZ_W;
   endfunction

   // Half ops only look at addr[1] and word ops ignore the lane entirely, so a
   // misaligned address silently truncates unless the caller checks this first.
   function automatic logic misaligned(input logic [7:0] op, input logic [1:0] lane);
      return acc_size(op) == SZ_H ? lane[0] : acc_size(op) == SZ_W ? |lane : 1'b0;
   endfunction

   function automatic logic [3:0] lane_sel(input logic [7:0] op, input logic [1:0] lane);
      return acc_size(op) == SZ_B ? 4'b0001 << lane :
             acc_size(op) == SZ_H ? (lane[1] ? 4'b1100 : 4'b0011) : 4'b1111;
   endfunction

   // Store data is replicated across lanes so the selected lanes carry it
   // regardless of the address.
   function automatic RegBus store_data(input logic [7:0] op, input RegBus reg2);
      return acc_size(op) == SZ_B ? {4{reg2[7:0]}} :
             acc_size(op) == SZ_H ? {2{reg2[15:0]}} : reg2;
   endfunction

endpackage

// File: rtl/mem_load_fmt.sv
// mem_load_fmt: selects the addressed lane of load data and sign/zero extends it
//   aluop_i  load opcode (LB/LBU/LH/LHU/LW)
//   lane_i   byte lane, addr[1:0]
//   rdata_i  raw bus read data
//   data_o   formatted register write data
module mem_load_fmt
   import mem_access_unit_pkg::*;
(
   input  logic [7:0]  aluop_i,
   input  logic [1:0]  lane_i,
   input  logic [31:0] rdata_i,
   output logic [31:0] data_o
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      byte_v = rdata_i[{lane_i, 3'b000} +: 8];
      half_v = lane_i[1] ? rdata_i[31:16] : rdata_i[15:0];
      data_o = aluop_i == EXE_LB_OP  ? {{24{byte_v[7]}}, byte_v} :
               aluop_i == EXE_LBU_OP ? {24'h0, byte_v} :
               aluop_i == EXE_LH_OP  ? {{16{half_v[15]}}, half_v} :
               aluop_i == EXE_LHU_OP ? {16'h0, half_v} : rdata_i;
   end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM stage and MEM/WB latch, drives the data bus with a req/ack handshake
//   mem_*_i     EX/MEM pipeline register outputs (dest, write enable, ALU result, op, address, store data)
//   dbus_*      registered data bus request/we/addr/sel/wdata, ack and read data back
//   stall_req   combinational hold of IF..EX/MEM while an access is outstanding
//   wb_*        registered write-back destination, enable and data
//   Optional macro MEM_ALIGN_CHECK_EN adds mem_adel_o/mem_ades_o misalignment flags.
module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter int DBUS_AW = 32,
   parameter int DBUS_DW = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [4:0]         mem_wd_i,
   input  logic               mem_wreg_i,
   input  logic [31:0]        mem_wdata_i,
   input  logic [7:0]         mem_aluop_i,
   input  logic [31:0]        mem_addr_i,
   input  logic [31:0]        mem_reg2_i,
   output logic               dbus_req,
   output logic               dbus_we,
   output logic [DBUS_AW-1:0] dbus_addr,
   output logic [3:0]         dbus_sel,
   output logic [DBUS_DW-1:0] dbus_wdata,
   input  logic               dbus_ack,
   input  logic [DBUS_DW-1:0] dbus_rdata,
   output logic               stall_req,
   output logic [4:0]         wb_wd,
   output logic               wb_wreg,
   output logic [31:0]        wb_wdata
`ifdef MEM_ALIGN_CHECK_EN
   ,
   output logic               mem_adel_o,
   output logic               mem_ades_o
`endif
);

   mem_state_e state_q, state_d;

   logic ld, st, mis, go, done, busy_wait;
   logic [31:0] ld_data;

   logic               dbus_req_q, dbus_req_d;
   logic               dbus_we_q, dbus_we_d;
   logic [DBUS_AW-1:0] dbus_addr_q, dbus_addr_d;
   logic [3:0]         dbus_sel_q, dbus_sel_d;
   logic [DBUS_DW-1:0] dbus_wdata_q, dbus_wdata_d;
   logic [4:0]         wb_wd_q, wb_wd_d;
   logic               wb_wreg_q, wb_wreg_d;
   logic [31:0]        wb_wdata_q, wb_wdata_d;
   logic               adel_q, adel_d, ades_q, ades_d;

   mem_load_fmt u_fmt (
      .aluop_i (mem_aluop_i),
      .lane_i  (mem_addr_i[1:0]),
      .rdata_i (dbus_rdata),
      .data_o  (ld_data)
   );

   always_comb begin
      ld = is_load(mem_aluop_i);
      st = is_store(mem_aluop_i);
`ifdef MEM_ALIGN_CHECK_EN
      mis = (ld | st) & misaligned(mem_aluop_i, mem_addr_i[1:0]);
`else
      mis = 1'b0;
`endif
      go        = state_q == IDLE && (ld || st) && !mis;
      done      = state_q == BUSY && dbus_ack;
      busy_wait = state_q == BUSY && !dbus_ack;
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = go ? BUSY : done ? IDLE : state_q;
   end

   // EX/MEM holds its outputs while stalled, so the inputs seen at ack time
   // are still those of the outstanding access.
   always_comb begin
      stall_req    = !rst && (go || busy_wait) ? STALL : NOSTALL;
      dbus_req_d   = go || busy_wait;
      dbus_we_d    = go ? st : dbus_we_q;
      dbus_addr_d  = go ? {mem_addr_i[DBUS_AW-1:2], 2'b00} : dbus_addr_q;
      dbus_sel_d   = go ? lane_sel(mem_aluop_i, mem_addr_i[1:0]) : dbus_sel_q;
      dbus_wdata_d = go ? store_data(mem_aluop_i, mem_reg2_i) : dbus_wdata_q;
      wb_wd_d      = mem_wd_i;
      wb_wreg_d    = done || (state_q == IDLE && !(ld || st)) ? mem_wreg_i : 1'b0;
      wb_wdata_d   = done && ld ? ld_data : mem_wdata_i;
      adel_d       = state_q == IDLE && mis && ld;
      ades_d       = state_q == IDLE && mis && st;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dbus_req_q   <= 1'b0;
         dbus_we_q    <= 1'b0;
         dbus_addr_q  <= '0;
         dbus_sel_q   <= 4'b0000;
         dbus_wdata_q <= '0;
         wb_wd_q      <= NOPRegAddr;
         wb_wreg_q    <= 1'b0;
         wb_wdata_q   <= ZEROWORD;
         adel_q       <= 1'b0;
         ades_q       <= 1'b0;
      end else begin
         dbus_req_q   <= dbus_req_d;
         dbus_we_q    <= dbus_we_d;
         dbus_addr_q  <= dbus_addr_d;
         dbus_sel_q   <= dbus_sel_d;
         dbus_wdata_q <= dbus_wdata_d;
         wb_wd_q      <= wb_wd_d;
         wb_wreg_q    <= wb_wreg_d;
         wb_wdata_q   <= wb_wdata_d;
         adel_q       <= adel_d;
         ades_q       <= ades_d;
      end
   end

   assign dbus_req   = dbus_req_q;
   assign dbus_we    = dbus_we_q;
   assign dbus_addr  = dbus_addr_q;
   assign dbus_sel   = dbus_sel_q;
   assign dbus_wdata = dbus_wdata_q;
   assign wb_wd      = wb_wd_q;
   assign wb_wreg    = wb_wreg_q;
   assign wb_wdata   = wb_wdata_q;

`ifdef MEM_ALIGN_CHECK_EN
   assign mem_adel_o = adel_q;
   assign mem_ades_o = ades_q;
`else
   logic unused_flags;
   assign unused_flags = adel_q ^ ades_q;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed plus randomized checks of mem_access_unit against a byte-level model
module tb_mem_access_unit;
   import mem_access_unit_pkg::*;

   localparam logic [7:0] NOP_OP = 8'h00;
   localparam logic [7:0] ADD_OP = 8'b0010_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  mem_wd;
   logic        mem_wreg;
   logic [31:0] mem_wdata, mem_addr, mem_reg2;
   logic [7:0]  mem_aluop;
   logic        dbus_req, dbus_we, dbus_ack, stall_req, wb_wreg;
   logic [31:0] dbus_addr, dbus_wdata, dbus_rdata, wb_wdata;
   logic [3:0]  dbus_sel;
   logic [4:0]  wb_wd;
`ifdef MEM_ALIGN_CHECK_EN
   logic        adel, ades;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_access_unit dut (
      .clk         (clk),
      .rst         (rst),
      .mem_wd_i    (mem_wd),
      .mem_wreg_i  (mem_wreg),
      .mem_wdata_i (mem_wdata),
      .mem_aluop_i (mem_aluop),
      .mem_addr_i  (mem_addr),
      .mem_reg2_i  (mem_reg2),
      .dbus_req    (dbus_req),
      .dbus_we     (dbus_we),
      .dbus_addr   (dbus_addr),
      .dbus_sel    (dbus_sel),
      .dbus_wdata  (dbus_wdata),
      .dbus_ack    (dbus_ack),
      .dbus_rdata  (dbus_rdata),
      .stall_req   (stall_req),
      .wb_wd       (wb_wd),
      .wb_wreg     (wb_wreg),
      .wb_wdata    (wb_wdata)
`ifdef MEM_ALIGN_CHECK_EN
      ,
      .mem_adel_o  (adel),
      .mem_ades_o  (ades)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference model: an access covers sz bytes starting at the address rounded
   // down to a multiple of sz; loads shift that window down and extend it.
   function automatic int m_sz(input logic [7:0] op);
      return (op == EXE_LB_OP || op == EXE_LBU_OP || op == EXE_SB_OP) ? 1 :
             (op == EXE_LH_OP || op == EXE_LHU_OP || op == EXE_SH_OP) ? 2 : 4;
   endfunction

   function automatic int m_base(input logic [7:0] op, input logic [31:0] addr);
      int a = int'(addr[1:0]);
      return a / m_sz(op) * m_sz(op);
   endfunction

   function automatic logic m_is_ld(input logic [7:0] op);
      return op == EXE_LB_OP || op == EXE_LBU_OP || op == EXE_LH_OP ||
             op == EXE_LHU_OP || op == EXE_LW_OP;
   endfunction

   function automatic logic m_mis(input logic [7:0] op, input logic [31:0] addr);
      return (int'(addr[1:0]) % m_sz(op)) != 0;
   endfunction

   function automatic logic [3:0] m_sel(input logic [7:0] op, input logic [31:0] addr);
      logic [3:0] s = 4'b0000;
      for (int k = 0; k < 4; k++)
         if (k >= m_base(op, addr) && k < m_base(op, addr) + m_sz(op)) s[k] = 1'b1;
      return s;
   endfunction

   function automatic logic [31:0] m_wdata(input logic [7:0] op, input logic [31:0] reg2);
      logic [31:0] w;
      for (int k = 0; k < 4; k++) w[8*k +: 8] = reg2[8*(k % m_sz(op)) +: 8];
      return w;
   endfunction

   function automatic logic [31:0] m_load(input logic [7:0] op, input logic [31:0] addr,
                                          input logic [31:0] rdata);
      longint span = longint'(1) << (8 * m_sz(op));
      longint v = (longint'(rdata) >> (8 * m_base(op, addr))) % span;
      if ((op == EXE_LB_OP || op == EXE_LH_OP) && v >= span / 2) v = v - span;
      return v[31:0];
   endfunction

   task automatic nonmem(input logic [4:0] wd, input logic wreg, input logic [31:0] wdata);
      @(negedge clk);
      mem_aluop = ADD_OP; mem_wd = wd; mem_wreg = wreg; mem_wdata = wdata;
      mem_addr = $urandom; mem_reg2 = $urandom; dbus_ack = 1'b0;
      #1 chk("alu_stall", stall_req, 1'b0);
      @(negedge clk);
      chk("alu_wb_wd", wb_wd, wd);
      chk("alu_wb_wreg", wb_wreg, wreg);
      chk("alu_wb_wdata", wb_wdata, wdata);
      chk("alu_req", dbus_req, 1'b0);
      mem_aluop = NOP_OP;
   endtask

   task automatic access(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                         input logic [31:0] rdata, input int waits, input logic [4:0] wd,
                         input logic wreg);
      int n = 0;
      logic ld = m_is_ld(op);
      @(negedge clk);
      mem_aluop = op; mem_addr = addr; mem_reg2 = reg2; mem_wd = wd; mem_wreg = wreg;
      mem_wdata = $urandom; dbus_ack = 1'b0;
      #1 chk("stall_issue", stall_req, 1'b1);
      n += int'(stall_req);
      for (int i = 0; i <= waits; i++) begin
         @(negedge clk);
         chk("req", dbus_req, 1'b1);
         chk("we", dbus_we, !ld);
         chk("addr", dbus_addr, {addr[31:2], 2'b00});
         chk("sel", dbus_sel, m_sel(op, addr));
         if (!ld) chk("wdata", dbus_wdata, m_wdata(op, reg2));
         chk("bubble_wreg", wb_wreg, 1'b0);
         if (i < waits) begin
            chk("stall_busy", stall_req, 1'b1);
            n += int'(stall_req);
         end
      end
      dbus_ack = 1'b1; dbus_rdata = rdata;
      #1 chk("stall_ack", stall_req, 1'b0);
      chk("stall_cycles", n, waits + 1);
      @(negedge clk);
      dbus_ack = 1'b0; dbus_rdata = $urandom;
      chk("req_drop", dbus_req, 1'b0);
      chk("done_wreg", wb_wreg, wreg);
      if (ld) begin
         chk("ld_wd", wb_wd, wd);
         chk("ld_data", wb_wdata, m_load(op, addr, rdata));
      end
`ifdef MEM_ALIGN_CHECK_EN
      chk("adel_quiet", adel, 1'b0);
      chk("ades_quiet", ades, 1'b0);
`endif
      mem_aluop = NOP_OP;
   endtask

`ifdef MEM_ALIGN_CHECK_EN
   task automatic misalign(input logic [7:0] op, input logic [31:0] addr);
      @(negedge clk);
      mem_aluop = op; mem_addr = addr; mem_reg2 = $urandom; mem_wd = 5'd9; mem_wreg = 1'b1;
      dbus_ack = 1'b0;
      #1 chk("mis_stall", stall_req, 1'b0);
      @(negedge clk);
      mem_aluop = NOP_OP; mem_wreg = 1'b0;
      chk("mis_req", dbus_req, 1'b0);
      chk("mis_adel", adel, m_is_ld(op));
      chk("mis_ades", ades, !m_is_ld(op));
      chk("mis_wreg", wb_wreg, 1'b0);
      @(negedge clk);
      chk("mis_adel_clr", adel, 1'b0);
      chk("mis_ades_clr", ades, 1'b0);
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      logic [7:0] ops [9];
      logic [7:0] op;
      logic [31:0] a;
      ops = '{EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP,
              EXE_SB_OP, EXE_SH_OP, EXE_SW_OP, ADD_OP};
      rst = 1'b1; mem_wd = '0; mem_wreg = 1'b0; mem_wdata = '0; mem_aluop = NOP_OP;
      mem_addr = '0; mem_reg2 = '0; dbus_ack = 1'b0; dbus_rdata = '0;
      repeat (2) @(negedge clk);
      chk("rst_req", dbus_req, 1'b0);
      chk("rst_we", dbus_we, 1'b0);
      chk("rst_addr", dbus_addr, 32'h0);
      chk("rst_sel", dbus_sel, 4'h0);
      chk("rst_wdata", dbus_wdata, 32'h0);
      chk("rst_stall", stall_req, 1'b0);
      chk("rst_wb_wd", wb_wd, 5'd0);
      chk("rst_wb_wreg", wb_wreg, 1'b0);
      chk("rst_wb_wdata", wb_wdata, 32'h0);
      rst = 1'b0;

      nonmem(5'd3, 1'b1, 32'h0000_1234);

      access(EXE_LB_OP, 32'h0000_0102, 32'h0, 32'h0080_0000, 3, 5'd4, 1'b1);
      chk("lb_value", wb_wdata, 32'hFFFF_FF80);
      access(EXE_LBU_OP, 32'h0000_0102, 32'h0, 32'h0080_0000, 3, 5'd5, 1'b1);
      chk("lbu_value", wb_wdata, 32'h0000_0080);
      access(EXE_SH_OP, 32'h0000_0206, 32'hABCD_1234, 32'h0, 0, 5'd0, 1'b0);

      // Reset while BUSY, then a stray ack in IDLE.
      @(negedge clk);
      mem_aluop = EXE_LW_OP; mem_addr = 32'h0000_0400; mem_wd = 5'd7; mem_wreg = 1'b1;
      @(negedge clk);
      chk("pre_rst_req", dbus_req, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; mem_aluop = NOP_OP; mem_wreg = 1'b0;
      #1 chk("midrst_req", dbus_req, 1'b0);
      chk("midrst_stall", stall_req, 1'b0);
      chk("midrst_wreg", wb_wreg, 1'b0);
      dbus_ack = 1'b1; dbus_rdata = 32'hDEAD_BEEF;
      #1 chk("stray_ack_stall", stall_req, 1'b0);
      @(negedge clk);
      dbus_ack = 1'b0;
      chk("stray_ack_req", dbus_req, 1'b0);
      chk("stray_ack_wreg", wb_wreg, 1'b0);
      nonmem(5'd12, 1'b1, 32'hCAFE_0001);

`ifdef MEM_ALIGN_CHECK_EN
      misalign(EXE_LW_OP, 32'h0000_0301);
      misalign(EXE_SH_OP, 32'h0000_0303);
`endif

      for (int i = 0; i < 40; i++) begin
         op = ops[$urandom_range(0, 8)];
         a = $urandom;
         if (op == ADD_OP) nonmem(5'($urandom), 1'($urandom), $urandom);
`ifdef MEM_ALIGN_CHECK_EN
         else if (m_mis(op, a)) misalign(op, a);
`endif
         else access(op, a, $urandom, $urandom, $urandom_range(0, 3), 5'($urandom),
                     m_is_ld(op) ? 1'b1 : 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
